// File: rtl/gpr_file_2w2r_if.sv
// Register-file bus: issue-side read/scoreboard signals plus the two writeback ports.
// The master drives addresses, writes and scoreboard sets. The slave (the register file) returns read data and busy status.
interface gpr_file_2w2r_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              rd1_busy;
    logic              rd2_busy;
    logic              wa_en;
    logic [ADDR_W-1:0] wa_addr;
    logic [DATA_W-1:0] wa_data;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              sb_set_en;
    logic [ADDR_W-1:0] sb_set_addr;
    logic [DEPTH-1:0]  busy_vec;

    modport master (
        output ra1, ra2, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
               sb_set_en, sb_set_addr,
        input  rd1, rd2, rd1_busy, rd2_busy, busy_vec
    );

    modport slave (
        input  ra1, ra2, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
               sb_set_en, sb_set_addr,
        output rd1, rd2, rd1_busy, rd2_busy, busy_vec
    );
endinterface

// File: rtl/gpr_file_2w2r.sv
// 2-write/2-read general-purpose register file with per-register busy scoreboard,
// optional hardwired-zero R0 and optional write-to-read bypass.
module gpr_file_2w2r #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int R0_ZERO = 0,
    parameter int BYPASS  = 1
) (
    input logic            clk,
    input logic            rst_n,
    gpr_file_2w2r_if.slave bus
);
    localparam int   DEPTH = 1 << ADDR_W;
    localparam logic R0Z   = (R0_ZERO != 0);
    localparam logic BYP   = (BYPASS != 0);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;

    logic wa_ok, wb_ok, sb_ok;
    logic hit_a1, hit_b1, hit_a2, hit_b2;
    logic zero1, zero2;

    // Address-0 traffic is dropped at the source when R0 is hardwired.
    assign wa_ok = bus.wa_en     & ~(R0Z & (bus.wa_addr     == '0));
    assign wb_ok = bus.wb_en     & ~(R0Z & (bus.wb_addr     == '0));
    assign sb_ok = bus.sb_set_en & ~(R0Z & (bus.sb_set_addr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wa_ok) regs[bus.wa_addr] <= bus.wa_data;
            // Port B is assigned last so it wins an address collision.
            if (wb_ok) regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                // A newly issued producer outranks the retiring one.
                if (sb_ok && (bus.sb_set_addr == ADDR_W'(i))) begin
                    busy[i] <= 1'b1;
                end else if ((wa_ok && (bus.wa_addr == ADDR_W'(i))) ||
                             (wb_ok && (bus.wb_addr == ADDR_W'(i)))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    assign hit_a1 = BYP & wa_ok & (bus.wa_addr == bus.ra1);
    assign hit_b1 = BYP & wb_ok & (bus.wb_addr == bus.ra1);
    assign hit_a2 = BYP & wa_ok & (bus.wa_addr == bus.ra2);
    assign hit_b2 = BYP & wb_ok & (bus.wb_addr == bus.ra2);
    assign zero1  = R0Z & (bus.ra1 == '0);
    assign zero2  = R0Z & (bus.ra2 == '0);

    always_comb begin
        bus.rd1 = regs[bus.ra1];
        if (zero1)       bus.rd1 = '0;
        else if (hit_b1) bus.rd1 = bus.wb_data;
        else if (hit_a1) bus.rd1 = bus.wa_data;
    end

    always_comb begin
        bus.rd2 = regs[bus.ra2];
        if (zero2)       bus.rd2 = '0;
        else if (hit_b2) bus.rd2 = bus.wb_data;
        else if (hit_a2) bus.rd2 = bus.wa_data;
    end

    assign bus.busy_vec = busy & {{(DEPTH-1){1'b1}}, ~R0Z};
    assign bus.rd1_busy = bus.busy_vec[bus.ra1] & ~(hit_a1 | hit_b1);
    assign bus.rd2_busy = bus.busy_vec[bus.ra2] & ~(hit_a2 | hit_b2);
endmodule
